dmi_boot_sequencer: RTL and testbench
=====================================

Name: dmi_boot_sequencer

Overview:
- Synthesizable DMI master that brings up NrHarts harts through the RISC-V debug module after reset.
- For each hart in turn it halts the hart, writes dpc with the hart's boot address, optionally writes a0/a1 (hart id and DTB pointer), then resumes the hart.
- It sits between the SoC reset/boot-control logic and the debug module DMI port, muxed with the JTAG DTM. This lets silicon and FPGA builds boot a loaded image without an external debugger.

Parameters:
- NrHarts, 1, number of harts sequenced (hart ids 0..NrHarts-1, max 1024).
- XLEN, 32, width of each boot address.
- WriteArgs, 1, when 1 write a0=hart id and a1=DtbAddr before resume.
- DtbAddr, 32'h0001_1200, value written to a1.
- PollTimeout, 1024, maximum poll reads or busy retries per wait step before error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; starts the sequence when idle
- boot_addr_i  in  NrHarts*XLEN  per-hart boot address, slice h for hart h; sampled at start
- busy_o  out  1  sequence in progress
- done_o  out  1  sticky; sequence finished OK
- error_o  out  1  sticky; sequence aborted
- error_code_o  out  3  1=DMI failed, 2=halt timeout, 3=cmderr, 4=abstract busy timeout, 5=resume timeout, 6=DMI busy timeout
- cur_hart_o  out  10  hart currently addressed
- dmi_req_valid_o  out  1  DMI request valid
- dmi_req_ready_i  in  1  DMI request accepted
- dmi_req_addr_o  out  7  DM register address
- dmi_req_op_o  out  2  1=read, 2=write
- dmi_req_data_o  out  32  write data
- dmi_resp_valid_i  in  1  DMI response valid
- dmi_resp_ready_o  out  1  DMI response ready
- dmi_resp_data_i  in  32  read data
- dmi_resp_resp_i  in  2  0=ok, 2=failed, 3=busy

Behaviour:
- Reset values: all outputs 0, FSM in IDLE.
- Reset asserted mid-sequence: return to IDLE immediately and drop dmi_req_valid_o. DM state is not restored.
- DMI transaction rules:
  - One transaction outstanding at a time.
  - addr, op and data are stable while valid is high; the request completes on valid&&ready.
  - dmi_resp_ready_o is 1 only while awaiting a response. A response arriving on the same cycle as ready is accepted.
  - resp=3: reissue the identical request. Retries count toward PollTimeout; exceeding it gives code 6.
  - resp=2: ERROR with code 1.
- dmcontrol value: dmactive bit0=1, hartsello [25:16]=h[9:0], hartselhi [15:6]=0, plus the request bit named per state.
- States and transitions:
  - IDLE: on start_i, latch boot_addr_i, set h=0, clear done/error, set busy → ACTIVATE.
  - ACTIVATE: write 0x10 = dmactive → HALT_REQ.
  - HALT_REQ: write 0x10 with haltreq bit31 → HALT_POLL.
  - HALT_POLL: read 0x11 until allhalted (bit9) = 1 → WR_DATA0. Timeout gives code 2.
  - WR_DATA0: write 0x04 = argument. Arg 0 = boot_addr[h]; arg 1 = h (zero-extended); arg 2 = DtbAddr. → WR_CMD.
  - WR_CMD: write 0x17 = {cmdtype=0, aarsize[22:20]=2, transfer bit17=1, write bit16=1, regno[15:0]}. regno is 0x07B1 (dpc), 0x100A (a0) or 0x100B (a1) for args 0/1/2 → CMD_POLL.
  - CMD_POLL: read 0x16 until busy (bit12) = 0. If cmderr [10:8] ≠ 0: write 0x16 = 0x700 to clear it, then ERROR with code 3. Timeout gives code 4. Otherwise go to the next arg (back to WR_DATA0), or RESUME_REQ when the args are done. Only arg 0 is issued if WriteArgs=0.
  - RESUME_REQ: write 0x10 with resumereq bit30 (haltreq=0) → RESUME_POLL.
  - RESUME_POLL: read 0x11 until allresumeack (bit17) = 1. Timeout gives code 5.
  - RESUME_CLR: write 0x10 = dmactive plus hartsel. If h == NrHarts-1 → DONE; else h++ → HALT_REQ.
  - DONE: done_o=1, busy_o=0 → IDLE.
  - ERROR: error_o=1, error_code_o latched, busy_o=0 → IDLE.
- Poll counter:
  - Reset on entry to each wait step.
  - Incremented per poll read or busy retry.
  - Error when the count equals PollTimeout with the condition still unmet. PollTimeout=N allows exactly N reads.
- Polling issues a new read the cycle after a response. There is no idle gap requirement.
- start_i is ignored while busy. done_o/error_o clear on the next accepted start.
- cur_hart_o = h while busy; it holds its last value otherwise.

Test Plan:
- NrHarts=1, WriteArgs=0, boot_addr=0x8000_0000, DM model halts and resumes after 1 poll → exact write sequence 0x10=0x1, 0x10=0x8000_0001, 0x04=0x8000_0000, 0x17=0x0023_07B1, 0x10=0x4000_0001, 0x10=0x1; done_o=1, error_o=0.
- NrHarts=2, WriteArgs=1, addrs 0x8000_0000 / 0x8000_1000 → hart 1 dmcontrol writes carry 0x0001_0000. Hart 1 data0 writes are 0x8000_1000, 0x1 and 0x0001_1200, with regnos 0x07B1, 0x100A, 0x100B. done_o=1.
- Model never sets allhalted, PollTimeout=4 → exactly 4 reads of 0x11, then error_o=1, error_code_o=2, busy_o=0.
- abstractcs returns cmderr=2 → write 0x16=0x700 issued, error_code_o=3, no resume write issued.
- Random req_ready stalls plus resp=3 on the first two attempts of each access → each request is held stable until accepted and reissued identically. The final sequence matches the first scenario and done_o=1.
- Reset pulsed during CMD_POLL → all outputs 0 the same cycle. A subsequent start completes normally.

Source files
------------

// File: rtl/dmi_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dmi_boot_sequencer
// Purpose  : DMI master that boots NrHarts harts through the RISC-V debug
//            module. For each hart it halts the hart, writes dpc (and
//            optionally a0/a1) with abstract commands, then resumes it.
// Ports    : clk_i/rst_ni          clock, asynchronous active-low reset
//            start_i               one-cycle start pulse (ignored while busy)
//            boot_addr_i           per-hart boot address, slice h = hart h
//            busy_o/done_o/error_o status (done/error are sticky)
//            error_code_o          abort reason
//            cur_hart_o            hart currently addressed
//            dmi_req_*/dmi_resp_*  DMI request/response handshakes
// Revision : 1.0 - initial release
// ============================================================================
module dmi_boot_sequencer #(
    parameter int unsigned NrHarts     = 1,
    parameter int unsigned XLEN        = 32,
    parameter bit          WriteArgs   = 1'b1,
    parameter logic [31:0] DtbAddr     = 32'h0001_1200,
    parameter int unsigned PollTimeout = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [NrHarts*XLEN-1:0] boot_addr_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [2:0]              error_code_o,
    output logic [9:0]              cur_hart_o,
    output logic                    dmi_req_valid_o,
    input  logic                    dmi_req_ready_i,
    output logic [6:0]              dmi_req_addr_o,
    output logic [1:0]              dmi_req_op_o,
    output logic [31:0]             dmi_req_data_o,
    input  logic                    dmi_resp_valid_i,
    output logic                    dmi_resp_ready_o,
    input  logic [31:0]             dmi_resp_data_i,
    input  logic [1:0]              dmi_resp_resp_i
);

    localparam logic [6:0] c_addr_data0     = 7'h04;
    localparam logic [6:0] c_addr_dmcontrol = 7'h10;
    localparam logic [6:0] c_addr_dmstatus  = 7'h11;
    localparam logic [6:0] c_addr_abscs     = 7'h16;
    localparam logic [6:0] c_addr_command   = 7'h17;
    localparam logic [1:0] c_op_read        = 2'd1;
    localparam logic [1:0] c_op_write       = 2'd2;
    localparam logic [1:0] c_resp_ok        = 2'd0;
    localparam logic [1:0] c_resp_busy      = 2'd3;
    // cmdtype=0 (access register), aarsize=2, transfer=1, write=1
    localparam logic [31:0] c_cmd_base      = 32'h0023_0000;
    localparam int unsigned c_cnt_w         = $clog2(PollTimeout + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(PollTimeout);
    localparam logic [9:0]  c_last_hart     = 10'(NrHarts - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ACTIVATE, ST_HALT_REQ, ST_HALT_POLL, ST_WR_DATA0, ST_WR_CMD,
        ST_CMD_POLL, ST_CMD_CLR, ST_RESUME_REQ, ST_RESUME_POLL, ST_RESUME_CLR,
        ST_DONE, ST_ERROR
    } state_e;

    state_e                  state_q, state_d;
    logic                    wait_q, wait_d;     // request accepted, response pending
    logic [9:0]              hart_q, hart_d;
    logic [1:0]              arg_q, arg_d;       // 0=dpc, 1=a0, 2=a1
    logic [c_cnt_w-1:0]      cnt_q, cnt_d;
    logic [NrHarts*XLEN-1:0] boot_q, boot_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [2:0]              code_q, code_d;

    logic                    w_req_en;
    logic [6:0]              w_addr;
    logic [1:0]              w_op;
    logic [31:0]             w_data;
    logic [31:0]             w_dmc;
    logic [XLEN-1:0]         w_boot_cur;
    logic [XLEN+31:0]        w_boot_ext;
    logic [c_cnt_w-1:0]      w_cnt_inc;
    logic                    w_rsp_ok;
    logic                    w_err;
    logic [2:0]              w_err_code;
    logic                    w_unused;

    // dmactive plus hartsello; hartselhi stays zero (max 1024 harts)
    assign w_dmc     = {6'b0, hart_q, 15'b0, 1'b1};
    assign w_cnt_inc = cnt_q + 1'b1;

    // Boot address of the current hart, zero-extended or truncated to 32 bits
    always_comb begin
        w_boot_cur = '0;
        for (int h = 0; h < NrHarts; h++) begin
            if (hart_q == 10'(h)) w_boot_cur = boot_q[h*XLEN +: XLEN];
        end
    end
    assign w_boot_ext = {32'b0, w_boot_cur};
    assign w_unused   = ^{dmi_resp_data_i, w_boot_ext[XLEN+31:32]};

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        hart_d     = hart_q;
        arg_d      = arg_q;
        cnt_d      = cnt_q;
        boot_d     = boot_q;
        done_d     = done_q;
        error_d    = error_q;
        code_d     = code_q;
        w_req_en   = 1'b0;
        w_addr     = '0;
        w_op       = '0;
        w_data     = '0;
        w_rsp_ok   = 1'b0;
        w_err      = 1'b0;
        w_err_code = '0;

        // Request owned by the current state; fields depend only on
        // registered state, so they are stable for the whole handshake.
        case (state_q)
            ST_ACTIVATE:    begin w_req_en = 1'b1; w_addr = c_addr_dmcontrol; w_op = c_op_write; w_data = 32'h1; end
            ST_HALT_REQ:    begin w_req_en = 1'b1; w_addr = c_addr_dmcontrol; w_op = c_op_write; w_data = w_dmc | 32'h8000_0000; end
            ST_HALT_POLL:   begin w_req_en = 1'b1; w_addr = c_addr_dmstatus;  w_op = c_op_read; end
            ST_WR_DATA0: begin
                w_req_en = 1'b1; w_addr = c_addr_data0; w_op = c_op_write;
                case (arg_q)
                    2'd0:    w_data = w_boot_ext[31:0];
                    2'd1:    w_data = {22'b0, hart_q};
                    default: w_data = DtbAddr;
                endcase
            end
            ST_WR_CMD: begin
                w_req_en = 1'b1; w_addr = c_addr_command; w_op = c_op_write;
                case (arg_q)
                    2'd0:    w_data = c_cmd_base | 32'h07B1;
                    2'd1:    w_data = c_cmd_base | 32'h100A;
                    default: w_data = c_cmd_base | 32'h100B;
                endcase
            end
            ST_CMD_POLL:    begin w_req_en = 1'b1; w_addr = c_addr_abscs;     w_op = c_op_read; end
            ST_CMD_CLR:     begin w_req_en = 1'b1; w_addr = c_addr_abscs;     w_op = c_op_write; w_data = 32'h0000_0700; end
            ST_RESUME_REQ:  begin w_req_en = 1'b1; w_addr = c_addr_dmcontrol; w_op = c_op_write; w_data = w_dmc | 32'h4000_0000; end
            ST_RESUME_POLL: begin w_req_en = 1'b1; w_addr = c_addr_dmstatus;  w_op = c_op_read; end
            ST_RESUME_CLR:  begin w_req_en = 1'b1; w_addr = c_addr_dmcontrol; w_op = c_op_write; w_data = w_dmc; end
            default: ;
        endcase

        // Single-outstanding DMI engine. A busy response leaves the state
        // unchanged so the identical request is reissued next cycle.
        if (w_req_en) begin
            if (!wait_q) begin
                if (dmi_req_ready_i) wait_d = 1'b1;
            end else if (dmi_resp_valid_i) begin
                wait_d = 1'b0;
                if (dmi_resp_resp_i == c_resp_busy) begin
                    if (w_cnt_inc == c_cnt_max) begin
                        w_err = 1'b1; w_err_code = 3'd6;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end else if (dmi_resp_resp_i == c_resp_ok) begin
                    w_rsp_ok = 1'b1;
                end else begin
                    w_err = 1'b1; w_err_code = 3'd1;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    boot_d  = boot_addr_i;
                    hart_d  = '0;
                    arg_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    code_d  = '0;
                    state_d = ST_ACTIVATE;
                end
            end
            ST_ACTIVATE:   if (w_rsp_ok) state_d = ST_HALT_REQ;
            ST_HALT_REQ:   if (w_rsp_ok) state_d = ST_HALT_POLL;
            ST_HALT_POLL: begin
                if (w_rsp_ok) begin
                    if (dmi_resp_data_i[9]) begin
                        arg_d = '0; state_d = ST_WR_DATA0;
                    end else if (w_cnt_inc == c_cnt_max) begin
                        w_err = 1'b1; w_err_code = 3'd2;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
            end
            ST_WR_DATA0:   if (w_rsp_ok) state_d = ST_WR_CMD;
            ST_WR_CMD:     if (w_rsp_ok) state_d = ST_CMD_POLL;
            ST_CMD_POLL: begin
                if (w_rsp_ok) begin
                    if (dmi_resp_data_i[12]) begin
                        if (w_cnt_inc == c_cnt_max) begin
                            w_err = 1'b1; w_err_code = 3'd4;
                        end else begin
                            cnt_d = w_cnt_inc;
                        end
                    end else if (dmi_resp_data_i[10:8] != 3'd0) begin
                        state_d = ST_CMD_CLR;
                    end else if (WriteArgs && arg_q != 2'd2) begin
                        arg_d = arg_q + 2'd1; state_d = ST_WR_DATA0;
                    end else begin
                        state_d = ST_RESUME_REQ;
                    end
                end
            end
            ST_CMD_CLR: if (w_rsp_ok) begin w_err = 1'b1; w_err_code = 3'd3; end
            ST_RESUME_REQ: if (w_rsp_ok) state_d = ST_RESUME_POLL;
            ST_RESUME_POLL: begin
                if (w_rsp_ok) begin
                    if (dmi_resp_data_i[17]) begin
                        state_d = ST_RESUME_CLR;
                    end else if (w_cnt_inc == c_cnt_max) begin
                        w_err = 1'b1; w_err_code = 3'd5;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
            end
            ST_RESUME_CLR: begin
                if (w_rsp_ok) begin
                    if (hart_q == c_last_hart) begin
                        done_d = 1'b1; state_d = ST_DONE;
                    end else begin
                        hart_d = hart_q + 10'd1; arg_d = '0; state_d = ST_HALT_REQ;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (w_err) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            code_d  = w_err_code;
        end
        // Each wait step starts with a fresh poll/retry budget
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            wait_q  <= 1'b0;
            hart_q  <= '0;
            arg_q   <= '0;
            cnt_q   <= '0;
            boot_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            hart_q  <= hart_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            boot_q  <= boot_d;
            done_q  <= done_d;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end

    assign busy_o           = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign error_code_o     = code_q;
    assign cur_hart_o       = hart_q;
    assign dmi_req_valid_o  = w_req_en && !wait_q;
    assign dmi_resp_ready_o = w_req_en && wait_q;
    assign dmi_req_addr_o   = w_addr;
    assign dmi_req_op_o     = w_op;
    assign dmi_req_data_o   = w_data;

endmodule
`default_nettype wire

// File: tb/tb_dmi_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmi_boot_sequencer
// Purpose  : Directed bench for dmi_boot_sequencer with a behavioural debug
//            module model and a write scoreboard. Instance A: 1 hart, no
//            args, PollTimeout=4. Instance B: 2 harts with args.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmi_boot_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sel;                      // 0 = instance A on the model, 1 = B
    logic a_start, b_start;
    logic [31:0] a_boot;
    logic [63:0] b_boot;

    logic a_busy, a_done, a_error, b_busy, b_done, b_error;
    logic [2:0] a_code, b_code;
    logic [9:0] a_hart, b_hart;
    logic a_req_valid, b_req_valid, a_req_ready, b_req_ready;
    logic [6:0] a_addr, b_addr;
    logic [1:0] a_op, b_op;
    logic [31:0] a_wdata, b_wdata;
    logic a_resp_valid, b_resp_valid, a_resp_ready, b_resp_ready;

    logic m_ready, m_resp_valid;
    logic [1:0] m_resp;
    logic [31:0] m_rdata;

    dmi_boot_sequencer #(.NrHarts(1), .XLEN(32), .WriteArgs(1'b0),
                         .DtbAddr(32'h0001_1200), .PollTimeout(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .boot_addr_i(a_boot),
        .busy_o(a_busy), .done_o(a_done), .error_o(a_error), .error_code_o(a_code),
        .cur_hart_o(a_hart), .dmi_req_valid_o(a_req_valid), .dmi_req_ready_i(a_req_ready),
        .dmi_req_addr_o(a_addr), .dmi_req_op_o(a_op), .dmi_req_data_o(a_wdata),
        .dmi_resp_valid_i(a_resp_valid), .dmi_resp_ready_o(a_resp_ready),
        .dmi_resp_data_i(m_rdata), .dmi_resp_resp_i(m_resp));

    dmi_boot_sequencer #(.NrHarts(2), .XLEN(32), .WriteArgs(1'b1),
                         .DtbAddr(32'h0001_1200), .PollTimeout(1024)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .boot_addr_i(b_boot),
        .busy_o(b_busy), .done_o(b_done), .error_o(b_error), .error_code_o(b_code),
        .cur_hart_o(b_hart), .dmi_req_valid_o(b_req_valid), .dmi_req_ready_i(b_req_ready),
        .dmi_req_addr_o(b_addr), .dmi_req_op_o(b_op), .dmi_req_data_o(b_wdata),
        .dmi_resp_valid_i(b_resp_valid), .dmi_resp_ready_o(b_resp_ready),
        .dmi_resp_data_i(m_rdata), .dmi_resp_resp_i(m_resp));

    logic s_valid, s_resp_ready;
    logic [6:0] s_addr;
    logic [1:0] s_op;
    logic [31:0] s_data;
    assign s_valid      = sel ? b_req_valid  : a_req_valid;
    assign s_resp_ready = sel ? b_resp_ready : a_resp_ready;
    assign s_addr       = sel ? b_addr       : a_addr;
    assign s_op         = sel ? b_op         : a_op;
    assign s_data       = sel ? b_wdata      : a_wdata;
    assign a_req_ready  = !sel && m_ready;
    assign b_req_ready  =  sel && m_ready;
    assign a_resp_valid = !sel && m_resp_valid;
    assign b_resp_valid =  sel && m_resp_valid;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected writes {addr, data}
    logic [38:0] exp_q[$];
    task automatic push_w(input logic [6:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Debug module model state
    bit stall_mode, busy_mode, halt_never, cmderr_mode;
    bit halted, resumed, acc_pend, prev_valid, retry_pend, cmdpoll_seen;
    int attempts, rd11;
    logic [40:0] acc_req, prev_req, retry_req;   // {addr, op, data}

    task automatic respond(input logic [40:0] r);
        logic [6:0] a;
        logic [1:0] o;
        logic [31:0] d;
        logic [38:0] e;
        {a, o, d} = r;
        m_rdata = '0;
        if (busy_mode && attempts < 2) begin
            attempts++;
            m_resp = 2'd3;
            retry_pend = 1'b1;
            retry_req = r;
        end else begin
            attempts = 0;
            m_resp = 2'd0;
            if (o == 2'd2) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_write", 64'({a, d}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_write", 64'({a, d}), 64'(e));
                end
                if (a == 7'h10 && d[31]) begin halted = !halt_never; resumed = 1'b0; end
                if (a == 7'h10 && d[30]) begin resumed = 1'b1; halted = 1'b0; end
            end else if (a == 7'h11) begin
                m_rdata = (halted ? 32'h0000_0200 : 32'h0) | (resumed ? 32'h0002_0000 : 32'h0);
            end else if (a == 7'h16) begin
                m_rdata = cmderr_mode ? 32'h0000_0200 : 32'h0;
            end
        end
        m_resp_valid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ready = 1'b0; m_resp_valid = 1'b0; m_resp = '0; m_rdata = '0;
            acc_pend = 1'b0; prev_valid = 1'b0; retry_pend = 1'b0; cmdpoll_seen = 1'b0;
            attempts = 0; rd11 = 0; halted = 1'b0; resumed = 1'b0;
        end else begin
            if (m_resp_valid) m_resp_valid = 1'b0;
            if (acc_pend) begin
                acc_pend = 1'b0;
                check("resp_ready", 64'(s_resp_ready), 64'd1);
                respond(acc_req);
            end
            if (prev_valid)
                check("req_stable", 64'({s_valid, s_addr, s_op, s_data}), 64'({1'b1, prev_req}));
            m_ready = stall_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
            prev_valid = 1'b0;
            if (s_valid && m_ready) begin
                acc_pend = 1'b1;
                acc_req  = {s_addr, s_op, s_data};
                if (retry_pend) begin
                    check("reissue", 64'(acc_req), 64'(retry_req));
                    retry_pend = 1'b0;
                end
                if (s_addr == 7'h11 && s_op == 2'd1) rd11++;
                if (s_addr == 7'h16 && s_op == 2'd1) cmdpoll_seen = 1'b1;
            end else if (s_valid) begin
                prev_valid = 1'b1;
                prev_req   = {s_addr, s_op, s_data};
            end
        end
    end

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input bit which, input string tag);
        @(negedge clk);
        if (which) b_start = 1'b1; else a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0;
        check({tag, "_started"}, 64'(which ? {b_busy, b_done, b_error} : {a_busy, a_done, a_error}), 64'b100);
    endtask

    task automatic wait_end(input bit which, input string tag);
        int n = 0;
        while (!(which ? (b_done | b_error) : (a_done | a_error)) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finish"}, 64'(which ? (b_done | b_error) : (a_done | a_error)), 64'd1);
    endtask

    task automatic push_s1();
        push_w(7'h10, 32'h0000_0001);
        push_w(7'h10, 32'h8000_0001);
        push_w(7'h04, 32'h8000_0000);
        push_w(7'h17, 32'h0023_07B1);
        push_w(7'h10, 32'h4000_0001);
        push_w(7'h10, 32'h0000_0001);
    endtask

    initial begin
        int base;
        logic [31:0] hs;
        rst_n = 1'b0; sel = 1'b0; a_start = 1'b0; b_start = 1'b0;
        a_boot = 32'h8000_0000;
        b_boot = 64'h8000_1000_8000_0000;
        stall_mode = 1'b0; busy_mode = 1'b0; halt_never = 1'b0; cmderr_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a_outputs", 64'({a_busy, a_done, a_error, a_code, a_hart, a_req_valid,
              a_resp_ready, a_addr, a_op, a_wdata}), 64'd0);
        check("reset_b_status", 64'({b_busy, b_done, b_error, b_code, b_hart, b_req_valid}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single hart, dpc only
        push_s1();
        pulse_start(1'b0, "s1");
        wait_end(1'b0, "s1");
        check("s1_status", 64'({a_done, a_error, a_code}), 64'b1_0_000);
        @(negedge clk);
        check("s1_idle", 64'({a_busy, a_done}), 64'b01);
        check("s1_sb_empty", 64'(exp_q.size()), 64'd0);

        // Hart never halts: exactly PollTimeout dmstatus reads
        halt_never = 1'b1;
        base = rd11;
        push_w(7'h10, 32'h0000_0001);
        push_w(7'h10, 32'h8000_0001);
        pulse_start(1'b0, "s3");
        wait_end(1'b0, "s3");
        repeat (2) @(negedge clk);
        check("s3_status", 64'({a_busy, a_done, a_error, a_code}), 64'b0_0_1_010);
        check("s3_reads", 64'(rd11 - base), 64'd4);
        check("s3_sb_empty", 64'(exp_q.size()), 64'd0);
        halt_never = 1'b0;

        // Abstract command error: cmderr cleared, no resume
        cmderr_mode = 1'b1;
        push_w(7'h10, 32'h0000_0001);
        push_w(7'h10, 32'h8000_0001);
        push_w(7'h04, 32'h8000_0000);
        push_w(7'h17, 32'h0023_07B1);
        push_w(7'h16, 32'h0000_0700);
        pulse_start(1'b0, "s4");
        wait_end(1'b0, "s4");
        repeat (10) @(negedge clk);
        check("s4_status", 64'({a_busy, a_done, a_error, a_code}), 64'b0_0_1_011);
        check("s4_sb_empty", 64'(exp_q.size()), 64'd0);
        cmderr_mode = 1'b0;

        // Ready stalls and two busy responses per access
        do_reset();
        stall_mode = 1'b1; busy_mode = 1'b1;
        push_s1();
        pulse_start(1'b0, "s5");
        wait_end(1'b0, "s5");
        check("s5_status", 64'({a_done, a_error, a_code}), 64'b1_0_000);
        check("s5_sb_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        stall_mode = 1'b0; busy_mode = 1'b0;

        // Two harts with a0/a1 arguments
        do_reset();
        sel = 1'b1;
        push_w(7'h10, 32'h0000_0001);
        for (int h = 0; h < 2; h++) begin
            hs = 32'(h) << 16;
            push_w(7'h10, 32'h8000_0001 | hs);
            push_w(7'h04, (h == 0) ? 32'h8000_0000 : 32'h8000_1000);
            push_w(7'h17, 32'h0023_07B1);
            push_w(7'h04, 32'(h));
            push_w(7'h17, 32'h0023_100A);
            push_w(7'h04, 32'h0001_1200);
            push_w(7'h17, 32'h0023_100B);
            push_w(7'h10, 32'h4000_0001 | hs);
            push_w(7'h10, 32'h0000_0001 | hs);
        end
        pulse_start(1'b1, "s2");
        repeat (20) @(negedge clk);
        b_start = 1'b1;                 // must be ignored while busy
        @(negedge clk);
        b_start = 1'b0;
        check("s2_still_busy", 64'(b_busy), 64'd1);
        wait_end(1'b1, "s2");
        check("s2_status", 64'({b_done, b_error, b_code}), 64'b1_0_000);
        check("s2_cur_hart", 64'(b_hart), 64'd1);
        check("s2_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset during CMD_POLL, then a clean run
        do_reset();
        sel = 1'b0;
        push_s1();
        pulse_start(1'b0, "s6");
        for (int n = 0; n < 200 && !cmdpoll_seen; n++) @(negedge clk);
        check("s6_cmdpoll_seen", 64'(cmdpoll_seen), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_reset_outputs", 64'({a_busy, a_done, a_error, a_code, a_hart, a_req_valid,
              a_resp_ready, a_addr, a_op, a_wdata}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
        push_s1();
        pulse_start(1'b0, "s6b");
        wait_end(1'b0, "s6b");
        check("s6_status", 64'({a_done, a_error, a_code}), 64'b1_0_000);
        check("s6_sb_empty", 64'(exp_q.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
